hazard_sequencer: RTL and testbench
===================================

HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
REQ-004 SHALL have: id_halt  in  1  control-unit halt decode for the instruction in ID.
REQ-005 SHALL have: ex_rs1, ex_rs2, ex_rd  in  5 each  EX-stage register fields.
REQ-006 SHALL have: ex_regWrite, ex_ld  in  1 each  EX-stage write-enable and load flag.
REQ-007 SHALL have: mem_rd  in  5; mem_regWrite, mem_ld  in  1 each  MEM-stage fields.
REQ-008 SHALL have: wb_rd  in  5; wb_regWrite  in  1  WB-stage fields.
REQ-009 SHALL have: branch_taken  in  1  EX redirect (beq/bne taken, jal, jalr).
REQ-010 SHALL have outputs: pc_en, ifid_en, ifid_flush, nop  out  1 each; nop drives the control-unit bubble input.
REQ-011 SHALL have: fwdA, fwdB  out  2 each  ALU operand forward select (00 regfile, 01 WB, 10 MEM).
REQ-012 SHALL have: halted  out  1; stall_cnt, flush_cnt  out  16 each  saturating performance counters.

Function
REQ-013 SHALL detect load-use: ex_ld & ex_regWrite & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
REQ-014 On load-use (no redirect), SHALL drive pc_en=0, ifid_en=0, nop=1, ifid_flush=0 in the same cycle; no registered delay.
REQ-015 On branch_taken, SHALL drive ifid_flush=1, nop=1, pc_en=1, ifid_en=1; branch_taken has priority over load-use.
REQ-016 With neither event in RUN, SHALL drive pc_en=1, ifid_en=1, nop=0, ifid_flush=0.
REQ-017 fwdA SHALL be 10 if mem_regWrite & ~mem_ld & mem_rd!=0 & mem_rd==ex_rs1; else 01 if wb_regWrite & wb_rd!=0 & wb_rd==ex_rs1; else 00.
REQ-018 fwdB SHALL follow REQ-017 using ex_rs2; MEM match SHALL win over WB match.
REQ-019 SHALL implement FSM RUN, DRAIN, HALTED with a 2-bit drain counter.
REQ-020 RUN->DRAIN when id_halt=1 & branch_taken=0 & no load-use; drain counter loads 3.
REQ-021 id_halt coincident with branch_taken SHALL be ignored (wrong-path); coincident with load-use SHALL be deferred until the stall clears.
REQ-022 In DRAIN and HALTED, SHALL drive pc_en=0, ifid_en=0, nop=1, ifid_flush=0; branch_taken, load-use and id_halt ignored.
REQ-023 DRAIN SHALL decrement the counter each cycle; DRAIN->HALTED on the cycle the counter is 1 (exactly 3 cycles in DRAIN).
REQ-024 halted SHALL be 1 only in HALTED; HALTED SHALL persist until reset.
REQ-025 stall_cnt SHALL increment once per RUN cycle with load-use stall (REQ-014); flush_cnt once per RUN cycle with branch_taken; both saturate at 16'hFFFF.
REQ-026 Forwarding outputs SHALL remain active in all states, including DRAIN, so retiring instructions resolve correctly.

Reset
REQ-027 On a clock edge with reset=1: state=RUN, drain counter=0, stall_cnt=0, flush_cnt=0, halted=0.
REQ-028 While reset=1, SHALL drive pc_en=0, ifid_en=0, nop=1, ifid_flush=1; fwdA=fwdB=00; counters SHALL not increment.
REQ-029 Reset asserted in DRAIN or HALTED SHALL return to RUN on that edge; no partial drain resumes.

Verification
REQ-030 Load-use: ex_ld=1, ex_regWrite=1, ex_rd=5, id_rs2=5 -> pc_en=0, ifid_en=0, nop=1 same cycle; stall_cnt 0->1.
REQ-031 Load to x0: ex_ld=1, ex_rd=0, id_rs1=0 -> no stall, pc_en=1, stall_cnt unchanged.
REQ-032 Forwarding: mem_rd=wb_rd=ex_rs1=7, both regWrite=1, mem_ld=0 -> fwdA=10; with mem_ld=1 -> fwdA=01.
REQ-033 Branch + load-use together -> ifid_flush=1, pc_en=1, nop=1; flush_cnt+1, stall_cnt unchanged.
REQ-034 Halt: id_halt=1 in RUN -> DRAIN for exactly 3 cycles, then halted=1 held 10+ cycles; id_halt with branch_taken=1 -> stays RUN.
REQ-035 Saturation/reset: force 65536 flushes -> flush_cnt holds 16'hFFFF; assert reset in DRAIN -> next cycle RUN, counters 0, halted=0.

Source files
------------

// File: rtl/hazard_sequencer.sv
// Hazard sequencer: load-use stall, branch flush, ALU forwarding,
// halt drain FSM and saturating stall/flush performance counters.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   id_rs1/id_rs2/id_halt ID-stage sources and halt decode
//   ex_*                  EX-stage register fields, write-enable, load flag
//   mem_*, wb_*           MEM/WB destination and write-enable for forwarding
//   branch_taken          EX redirect
//   pc_en, ifid_en        PC and IF/ID register enables
//   ifid_flush, nop       IF/ID flush and control-unit bubble
//   fwdA, fwdB            ALU operand select (00 regfile, 01 WB, 10 MEM)
//   halted                core fully drained and stopped
//   stall_cnt, flush_cnt  saturating performance counters
module hazard_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_halt,
    input  logic [4:0]  ex_rs1,
    input  logic [4:0]  ex_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_regWrite,
    input  logic        ex_ld,
    input  logic [4:0]  mem_rd,
    input  logic        mem_regWrite,
    input  logic        mem_ld,
    input  logic [4:0]  wb_rd,
    input  logic        wb_regWrite,
    input  logic        branch_taken,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        nop,
    output logic [1:0]  fwdA,
    output logic [1:0]  fwdB,
    output logic        halted,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    state_t     state_q, state_d;
    logic [1:0] drain_q, drain_d;
    logic       load_use;
    logic       stall_inc;
    logic       flush_inc;

    // A load result is not available from MEM, so a MEM-stage load
    // never forwards from MEM; WB covers it a cycle later.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] m_rd,
        input logic       m_we,
        input logic       m_ld,
        input logic [4:0] w_rd,
        input logic       w_we
    );
        if (m_we && !m_ld && m_rd != 5'd0 && m_rd == rs)
            return FWD_MEM;
        else if (w_we && w_rd != 5'd0 && w_rd == rs)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    assign load_use = ex_ld && ex_regWrite && ex_rd != 5'd0 &&
                      (ex_rd == id_rs1 || ex_rd == id_rs2);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            drain_q <= 2'd0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        nop        = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        if (reset) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            ifid_flush = 1'b1;
            nop        = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (branch_taken) begin
                        // Redirect wins; a halt in ID is wrong-path.
                        ifid_flush = 1'b1;
                        nop        = 1'b1;
                        flush_inc  = 1'b1;
                    end else if (load_use) begin
                        // Halt stays in ID and is taken once the stall clears.
                        pc_en     = 1'b0;
                        ifid_en   = 1'b0;
                        nop       = 1'b1;
                        stall_inc = 1'b1;
                    end else if (id_halt) begin
                        state_d = DRAIN;
                        drain_d = 2'd3;
                    end
                end
                DRAIN: begin
                    pc_en   = 1'b0;
                    ifid_en = 1'b0;
                    nop     = 1'b1;
                    drain_d = drain_q - 2'd1;
                    if (drain_q == 2'd1)
                        state_d = HALTED;
                end
                HALTED: begin
                    pc_en   = 1'b0;
                    ifid_en = 1'b0;
                    nop     = 1'b1;
                end
                default: begin
                    state_d = RUN;
                    drain_d = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            if (stall_inc && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (flush_inc && flush_cnt != 16'hFFFF)
                flush_cnt <= flush_cnt + 16'd1;
        end
    end

    // Forwarding stays live in DRAIN/HALTED so retiring ops resolve.
    always_comb begin
        fwdA = FWD_RF;
        fwdB = FWD_RF;
        if (!reset) begin
            fwdA = fwd_sel(ex_rs1, mem_rd, mem_regWrite, mem_ld,
                           wb_rd, wb_regWrite);
            fwdB = fwd_sel(ex_rs2, mem_rd, mem_regWrite, mem_ld,
                           wb_rd, wb_regWrite);
        end
    end

    assign halted = (state_q == HALTED) && !reset;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench for hazard_sequencer: directed vectors push
// hand-computed expectations, a negedge monitor pops and compares.
module tb_hazard_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2;
    logic        id_halt;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic        ex_regWrite, ex_ld;
    logic [4:0]  mem_rd;
    logic        mem_regWrite, mem_ld;
    logic [4:0]  wb_rd;
    logic        wb_regWrite;
    logic        branch_taken;
    logic        pc_en, ifid_en, ifid_flush, nop;
    logic [1:0]  fwdA, fwdB;
    logic        halted;
    logic [15:0] stall_cnt, flush_cnt;

    typedef struct packed {
        logic        pc;
        logic        ifid;
        logic        fl;
        logic        nop;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        h;
        logic [15:0] s;
        logic [15:0] f;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    always #5 clk = ~clk;

    hazard_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_halt      (id_halt),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_rd        (ex_rd),
        .ex_regWrite  (ex_regWrite),
        .ex_ld        (ex_ld),
        .mem_rd       (mem_rd),
        .mem_regWrite (mem_regWrite),
        .mem_ld       (mem_ld),
        .wb_rd        (wb_rd),
        .wb_regWrite  (wb_regWrite),
        .branch_taken (branch_taken),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .ifid_flush   (ifid_flush),
        .nop          (nop),
        .fwdA         (fwdA),
        .fwdB         (fwdB),
        .halted       (halted),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    function automatic exp_t e(
        input logic pc, ifid, fl, np,
        input logic [1:0] fa, fb,
        input logic h,
        input logic [15:0] s, f
    );
        exp_t r;
        r = '{pc, ifid, fl, np, fa, fb, h, s, f};
        return r;
    endfunction

    task automatic idle();
        reset = 1'b0;
        id_rs1 = 0; id_rs2 = 0; id_halt = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
        ex_regWrite = 0; ex_ld = 0;
        mem_rd = 0; mem_regWrite = 0; mem_ld = 0;
        wb_rd = 0; wb_regWrite = 0;
        branch_taken = 0;
    endtask

    task automatic go();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic issue(input string nm, input exp_t x);
        exp_q.push_back(x);
        name_q.push_back(nm);
    endtask

    task automatic load_use5();
        ex_ld = 1; ex_regWrite = 1; ex_rd = 5; id_rs1 = 5;
    endtask

    // Monitor: outputs are combinational, so every negedge with a
    // pending expectation is a presented response.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  x;
            exp_t  a;
            string nm;
            x  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = '{pc_en, ifid_en, ifid_flush, nop, fwdA, fwdB,
                   halted, stall_cnt, flush_cnt};
            n_cmp++;
            if (a !== x) begin
                n_bad++;
                $display("FAIL %s: got pc=%b ifid=%b fl=%b nop=%b fa=%b fb=%b h=%b s=%h f=%h want pc=%b ifid=%b fl=%b nop=%b fa=%b fb=%b h=%b s=%h f=%h",
                         nm, a.pc, a.ifid, a.fl, a.nop, a.fa, a.fb, a.h, a.s, a.f,
                         x.pc, x.ifid, x.fl, x.nop, x.fa, x.fb, x.h, x.s, x.f);
            end
        end
    end

    initial begin
        idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1; branch_taken = 1; load_use5();
        mem_rd = 7; mem_regWrite = 1; ex_rs1 = 7;
        issue("reset_out", e(0,0,1,1,2'b00,2'b00,0,0,0));

        go();
        issue("reset_noinc", e(1,1,0,0,0,0,0,0,0));

        go();
        ex_ld = 1; ex_regWrite = 1; ex_rd = 5; id_rs2 = 5;
        issue("load_use", e(0,0,0,1,0,0,0,0,0));
        go();
        issue("stall_cnt1", e(1,1,0,0,0,0,0,1,0));

        go();
        ex_ld = 1; ex_regWrite = 1; ex_rd = 0; id_rs1 = 0;
        issue("load_x0", e(1,1,0,0,0,0,0,1,0));
        go();
        issue("load_x0_cnt", e(1,1,0,0,0,0,0,1,0));

        go();
        mem_rd = 7; wb_rd = 7; ex_rs1 = 7;
        mem_regWrite = 1; wb_regWrite = 1;
        issue("fwdA_mem", e(1,1,0,0,2'b10,2'b00,0,1,0));
        go();
        mem_rd = 7; wb_rd = 7; ex_rs1 = 7;
        mem_regWrite = 1; wb_regWrite = 1; mem_ld = 1;
        issue("fwdA_wb_ld", e(1,1,0,0,2'b01,2'b00,0,1,0));
        go();
        ex_rs1 = 3; mem_rd = 3; mem_regWrite = 1;
        ex_rs2 = 9; wb_rd = 9; wb_regWrite = 1;
        issue("fwdB_wb", e(1,1,0,0,2'b10,2'b01,0,1,0));
        go();
        ex_rs2 = 4; mem_rd = 4; wb_rd = 4;
        mem_regWrite = 1; wb_regWrite = 1;
        issue("fwdB_mem", e(1,1,0,0,2'b00,2'b10,0,1,0));
        go();
        mem_rd = 0; wb_rd = 0; mem_regWrite = 1; wb_regWrite = 1;
        issue("fwd_x0", e(1,1,0,0,2'b00,2'b00,0,1,0));

        go();
        branch_taken = 1; load_use5();
        issue("br_loaduse", e(1,1,1,1,0,0,0,1,0));
        go();
        issue("br_cnt", e(1,1,0,0,0,0,0,1,1));

        go();
        id_halt = 1; branch_taken = 1;
        issue("halt_br", e(1,1,1,1,0,0,0,1,1));
        go();
        issue("halt_br_run", e(1,1,0,0,0,0,0,1,2));

        go();
        id_halt = 1; load_use5();
        issue("halt_stall", e(0,0,0,1,0,0,0,1,2));
        go();
        id_halt = 1;
        issue("halt_defer", e(1,1,0,0,0,0,0,2,2));
        go();
        id_halt = 1; branch_taken = 1; load_use5();
        ex_rs1 = 4; mem_rd = 4; mem_regWrite = 1;
        issue("drain1", e(0,0,0,1,2'b10,2'b00,0,2,2));
        go();
        issue("drain2", e(0,0,0,1,0,0,0,2,2));
        go();
        branch_taken = 1;
        issue("drain3", e(0,0,0,1,0,0,0,2,2));
        for (int i = 0; i < 12; i++) begin
            go();
            branch_taken = i[0];
            issue("halted_hold", e(0,0,0,1,0,0,1,2,2));
        end

        go();
        reset = 1;
        issue("reset_halted", e(0,0,1,1,0,0,0,2,2));
        go();
        issue("post_reset", e(1,1,0,0,0,0,0,0,0));

        go();
        branch_taken = 1;
        issue("pre_br", e(1,1,1,1,0,0,0,0,0));
        go();
        load_use5();
        issue("pre_lu", e(0,0,0,1,0,0,0,0,1));
        go();
        id_halt = 1;
        issue("halt2", e(1,1,0,0,0,0,0,1,1));
        go();
        issue("drain_b1", e(0,0,0,1,0,0,0,1,1));
        go();
        reset = 1;
        issue("reset_drain", e(0,0,1,1,0,0,0,1,1));
        go();
        issue("after_rst1", e(1,1,0,0,0,0,0,0,0));
        go();
        issue("after_rst2", e(1,1,0,0,0,0,0,0,0));
        go();
        reset = 1;
        issue("pre_sat_rst", e(0,0,1,1,0,0,0,0,0));

        for (int i = 0; i < 65536; i++) begin
            go();
            branch_taken = 1;
            if (i < 2 || i == 40000 || i >= 65530)
                issue("sat_run", e(1,1,1,1,0,0,0,0,16'(i)));
        end
        go();
        issue("sat_hold", e(1,1,0,0,0,0,0,0,16'hFFFF));
        go();
        branch_taken = 1;
        issue("sat_more", e(1,1,1,1,0,0,0,0,16'hFFFF));
        go();
        issue("sat_hold2", e(1,1,0,0,0,0,0,0,16'hFFFF));

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_queue: got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
